// File: rtl/merge_stream_ctrl.sv
// -----------------------------------------------------------------------------
// merge_stream_ctrl
//
// Sequences an external odd-even merge network that combines two sorted
// N-word runs into one sorted 2N-word run. A run pair is accepted over a
// valid/ready handshake and held on the network inputs for SETTLE cycles
// (legal range 1..15). The network result is then captured and streamed out
// one word per beat, smallest (word 0) first, under valid/ready backpressure.
// Only one transaction is ever in flight.
//
// Optional feature (compile-time macro MERGE_SORT_CHECK_EN):
//   When defined, err is set at each accepted handshake if either input run
//   is not non-decreasing (unsigned), and cleared otherwise. Data is merged
//   and emitted regardless. When undefined, err is tied to 0.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   run pair on in_a/in_b is valid
//   in_ready   out  controller is idle and can accept a run pair
//   in_a/in_b  in   sorted runs, N words of WIDTH bits, word 0 in the LSBs
//   mrg_a/b    out  merge network inputs (registered copies of in_a/in_b)
//   mrg_c      in   merge network result, 2N words, word 0 in the LSBs
//   out_valid  out  out_data holds a valid merged word
//   out_ready  in   downstream accepts the current word
//   out_data   out  current merged word
//   out_last   out  current word is word 2N-1
//   busy       out  controller is not idle
//   err        out  input order violation (optional feature)
// -----------------------------------------------------------------------------
module merge_stream_ctrl #(
  parameter int WIDTH  = 3,
  parameter int N      = 4,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*WIDTH-1:0]     in_a,
  input  logic [N*WIDTH-1:0]     in_b,
  output logic [N*WIDTH-1:0]     mrg_a,
  output logic [N*WIDTH-1:0]     mrg_b,
  input  logic [2*N*WIDTH-1:0]   mrg_c,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   err
);

  localparam int                IDX_W    = $clog2(2 * N);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(2 * N - 1);
  localparam logic [3:0]        CNT_INIT = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t                  state_q;
  logic [N*WIDTH-1:0]      rega_q;
  logic [N*WIDTH-1:0]      regb_q;
  logic [2*N*WIDTH-1:0]    outbuf_q;
  logic [IDX_W-1:0]        idx_q;
  logic [3:0]              cnt_q;

  // Gating with rst keeps in_ready low for the whole reset pulse, not just
  // until the state register settles.
  assign in_ready = (state_q == IDLE) & ~rst;
  assign busy     = (state_q != IDLE);

  // The network sees the captured runs continuously; they only change at an
  // accepted handshake, so they are stable for the full settle window.
  assign mrg_a = rega_q;
  assign mrg_b = regb_q;

  // Stream outputs decode purely from registers: no path from out_ready,
  // so a stalled word stays stable until it is taken.
  assign out_valid = (state_q == EMIT);
  assign out_data  = out_valid ? outbuf_q[idx_q*WIDTH +: WIDTH] : '0;
  assign out_last  = out_valid & (idx_q == LAST_IDX);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others; blocking here would
  // make the result depend on statement order.
  // NOTE: outbuf is a plain register bank (not a RAM), so clearing it in reset
  // is cheap and guarantees out_data reads 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rega_q   <= '0;
      regb_q   <= '0;
      outbuf_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            rega_q  <= in_a;
            regb_q  <= in_b;
            cnt_q   <= CNT_INIT;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // Counts SETTLE-1 down to 0, so WAIT lasts exactly SETTLE cycles.
          if (cnt_q == 4'd0) begin
            outbuf_q <= mrg_c;
            idx_q    <= '0;
            state_q  <= EMIT;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q <= IDLE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MERGE_SORT_CHECK_EN
  logic err_q;
  logic sort_bad_d;

  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    sort_bad_d = 1'b0;
    for (int k = 0; k < N - 1; k++) begin
      if (in_a[(k+1)*WIDTH +: WIDTH] < in_a[k*WIDTH +: WIDTH]) sort_bad_d = 1'b1;
      if (in_b[(k+1)*WIDTH +: WIDTH] < in_b[k*WIDTH +: WIDTH]) sort_bad_d = 1'b1;
    end
  end

  // Updated only at an accepted handshake; holds through the transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (in_valid && state_q == IDLE) begin
      err_q <= sort_bad_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_merge_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_merge_stream_ctrl
//
// Two controller instances share clock and reset: inst 0 with SETTLE=1 and
// inst 1 with SETTLE=3. Each has a behavioural merge network that sorts the
// eight words it is given. Transactions come from a table of hand-computed
// vectors; reset-during-operation and reset state are covered by explicit
// sequences. Define MERGE_SORT_CHECK_EN to exercise the err output.
// -----------------------------------------------------------------------------
module tb_merge_stream_ctrl;

  localparam int W = 3;
  localparam int N = 4;

  typedef struct {
    int                sel;      // which instance
    int                settle;   // SETTLE of that instance
    logic [N*W-1:0]    a;
    logic [N*W-1:0]    b;
    logic [2*N*W-1:0]  exp;      // expected output words, word 0 in LSBs
    logic [15:0]       rdy;      // out_ready pattern, bit i used in stream cycle i%16
    logic              err_exp;  // expected err when the check is built
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  logic [1:0]        in_valid_v, in_ready_v, out_valid_v, out_ready_v;
  logic [1:0]        out_last_v, busy_v, err_v;
  logic [N*W-1:0]    in_a_v   [2];
  logic [N*W-1:0]    in_b_v   [2];
  logic [N*W-1:0]    mrg_a_v  [2];
  logic [N*W-1:0]    mrg_b_v  [2];
  logic [2*N*W-1:0]  mrg_c_v  [2];
  logic [W-1:0]      out_data_v [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural merge network: full sort of both runs, ascending.
  function automatic logic [2*N*W-1:0] merge_net(input logic [N*W-1:0] a,
                                                 input logic [N*W-1:0] b);
    logic [W-1:0]     w [2*N];
    logic [W-1:0]     t;
    logic [2*N*W-1:0] r;
    for (int i = 0; i < N; i++) begin
      w[i]     = a[i*W +: W];
      w[i + N] = b[i*W +: W];
    end
    for (int i = 0; i < 2*N; i++)
      for (int j = 0; j < 2*N - 1 - i; j++)
        if (w[j+1] < w[j]) begin
          t = w[j]; w[j] = w[j+1]; w[j+1] = t;
        end
    r = '0;
    for (int i = 0; i < 2*N; i++) r[i*W +: W] = w[i];
    return r;
  endfunction

  assign mrg_c_v[0] = merge_net(mrg_a_v[0], mrg_b_v[0]);
  assign mrg_c_v[1] = merge_net(mrg_a_v[1], mrg_b_v[1]);

  merge_stream_ctrl #(.WIDTH(W), .N(N), .SETTLE(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_a(in_a_v[0]), .in_b(in_b_v[0]),
    .mrg_a(mrg_a_v[0]), .mrg_b(mrg_b_v[0]), .mrg_c(mrg_c_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .out_data(out_data_v[0]), .out_last(out_last_v[0]),
    .busy(busy_v[0]), .err(err_v[0])
  );

  merge_stream_ctrl #(.WIDTH(W), .N(N), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_a(in_a_v[1]), .in_b(in_b_v[1]),
    .mrg_a(mrg_a_v[1]), .mrg_b(mrg_b_v[1]), .mrg_c(mrg_c_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .out_data(out_data_v[1]), .out_last(out_last_v[1]),
    .busy(busy_v[1]), .err(err_v[1])
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Handshake one run pair, check latency, then stream n_words under the
  // vector's out_ready pattern. Ends on a negedge; for a full transaction the
  // controller must be back in IDLE there.
  task automatic run_txn(input vec_t v, input int n_words);
    int   lat;
    int   k;
    int   cyc;
    logic exp_err;
`ifdef MERGE_SORT_CHECK_EN
    exp_err = v.err_exp;
`else
    exp_err = 1'b0;
`endif
    @(negedge clk);
    check("in_ready idle", in_ready_v[v.sel], 1'b1);
    in_a_v[v.sel]      = v.a;
    in_b_v[v.sel]      = v.b;
    in_valid_v[v.sel]  = 1'b1;
    out_ready_v[v.sel] = 1'b0;
    @(negedge clk);
    in_valid_v[v.sel] = 1'b0;
    in_a_v[v.sel]     = '0;
    in_b_v[v.sel]     = '0;
    check("busy after hs",     busy_v[v.sel],     1'b1);
    check("in_ready after hs", in_ready_v[v.sel], 1'b0);
    check("mrg_a held",        mrg_a_v[v.sel],    v.a);
    check("mrg_b held",        mrg_b_v[v.sel],    v.b);
    check("err",               err_v[v.sel],      exp_err);
    lat = 1;
    while (!out_valid_v[v.sel] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("first valid latency", lat, v.settle + 1);

    k = 0;
    cyc = 0;
    while (k < n_words && cyc < 64) begin
      out_ready_v[v.sel] = v.rdy[cyc % 16];
      check("out_valid",     out_valid_v[v.sel], 1'b1);
      check("out_data",      out_data_v[v.sel],  v.exp[k*W +: W]);
      check("out_last",      out_last_v[v.sel],  (k == 2*N - 1));
      check("in_ready emit", in_ready_v[v.sel],  1'b0);
      @(negedge clk);
      if (v.rdy[cyc % 16]) k++;
      cyc++;
    end
    check("words delivered", k, n_words);
    out_ready_v[v.sel] = 1'b0;
    if (n_words == 2*N) begin
      check("out_valid done", out_valid_v[v.sel], 1'b0);
      check("busy done",      busy_v[v.sel],      1'b0);
      check("in_ready done",  in_ready_v[v.sel],  1'b1);
      check("err held",       err_v[v.sel],       exp_err);
    end
  endtask

  vec_t vecs [5];

  initial begin
    // a=[1,3,5,7] b=[0,2,4,6] -> 0..7, free-flowing
    vecs[0] = '{sel: 0, settle: 1,
                a: {3'd7, 3'd5, 3'd3, 3'd1}, b: {3'd6, 3'd4, 3'd2, 3'd0},
                exp: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
                rdy: 16'hFFFF, err_exp: 1'b0};
    // same data, out_ready 1,0,0,1 repeating
    vecs[1] = '{sel: 0, settle: 1,
                a: {3'd7, 3'd5, 3'd3, 3'd1}, b: {3'd6, 3'd4, 3'd2, 3'd0},
                exp: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
                rdy: 16'b1001_1001_1001_1001, err_exp: 1'b0};
    // unsorted a=[3,1,4,5], b=[0,2,4,6]; network output 0,1,2,3,4,4,5,6
    vecs[2] = '{sel: 0, settle: 1,
                a: {3'd5, 3'd4, 3'd1, 3'd3}, b: {3'd6, 3'd4, 3'd2, 3'd0},
                exp: {3'd6, 3'd5, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
                rdy: 16'hFFFF, err_exp: 1'b1};
    // a=[0,0,1,1] b=[0,1,1,1] -> 0,0,0,1,1,1,1,1
    vecs[3] = '{sel: 0, settle: 1,
                a: {3'd1, 3'd1, 3'd0, 3'd0}, b: {3'd1, 3'd1, 3'd1, 3'd0},
                exp: {3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0},
                rdy: 16'hFFFF, err_exp: 1'b0};
    // SETTLE=3, all duplicates 2 -> eight 2s, with one early stall
    vecs[4] = '{sel: 1, settle: 3,
                a: {3'd2, 3'd2, 3'd2, 3'd2}, b: {3'd2, 3'd2, 3'd2, 3'd2},
                exp: {3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2},
                rdy: 16'b1111_1111_1111_1101, err_exp: 1'b0};

    rst         = 1'b1;
    in_valid_v  = '0;
    out_ready_v = '0;
    for (int s = 0; s < 2; s++) begin
      in_a_v[s] = '0;
      in_b_v[s] = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst in_ready",  in_ready_v[s],  1'b0);
      check("rst out_valid", out_valid_v[s], 1'b0);
      check("rst out_data",  out_data_v[s],  '0);
      check("rst out_last",  out_last_v[s],  1'b0);
      check("rst busy",      busy_v[s],      1'b0);
      check("rst err",       err_v[s],       1'b0);
      check("rst mrg_a",     mrg_a_v[s],     '0);
      check("rst mrg_b",     mrg_b_v[s],     '0);
    end
    rst = 1'b0;
    #1;
    check("post-rst in_ready", in_ready_v[0], 1'b1);
    check("post-rst busy",     busy_v[0],     1'b0);

    // Table-driven transactions on the SETTLE=1 instance
    for (int i = 0; i < 3; i++) run_txn(vecs[i], 2*N);

    // Reset in the middle of EMIT after three accepted words
    run_txn(vecs[0], 3);
    check("pre-rst out_valid", out_valid_v[0], 1'b1);
    check("pre-rst out_data",  out_data_v[0],  3'd3);
    #2 rst = 1'b1;
    #1;
    check("mid-rst out_valid", out_valid_v[0], 1'b0);
    check("mid-rst busy",      busy_v[0],      1'b0);
    check("mid-rst in_ready",  in_ready_v[0],  1'b0);
    check("mid-rst err",       err_v[0],       1'b0);
    check("mid-rst mrg_a",     mrg_a_v[0],     '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel in_ready", in_ready_v[0], 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("no replay valid", out_valid_v[0], 1'b0);
      check("no replay busy",  busy_v[0],      1'b0);
    end
    run_txn(vecs[3], 2*N);

    // Longer settle, duplicate keys, on the SETTLE=3 instance
    run_txn(vecs[4], 2*N);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d",
             checks, errors);
    $fatal(1, "watchdog timeout");
  end

endmodule

// File: doc/merge_stream_ctrl.md
Name: merge_stream_ctrl

Overview:
- Controller that sequences an external odd-even merge network of two N-word sorted runs into one 2N-word sorted run.
- Accepts both runs in parallel over a valid/ready handshake and holds them stable on the network inputs for a programmable settle time.
- Captures the merged result, then streams it out one word per beat, smallest first, under valid/ready backpressure.
- Sits between the record-collection front end and the downstream V2V priority logic.

Parameters:
- WIDTH, 3, bits per key word.
- N, 4, words per input run; the merge network output is 2N words.
- SETTLE, 1, cycles the network inputs are held before capture; legal range is 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input runs are valid.
- in_ready  out  1  controller can accept a run pair.
- in_a  in  N*WIDTH  sorted run A; word 0 in the LSBs and smallest.
- in_b  in  N*WIDTH  sorted run B; same packing as in_a.
- mrg_a  out  N*WIDTH  to merge network input a.
- mrg_b  out  N*WIDTH  to merge network input b.
- mrg_c  in  2*N*WIDTH  merge network result; word 0 in the LSBs.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the current word.
- out_data  out  WIDTH  current merged word.
- out_last  out  1  current word is word 2N-1.
- busy  out  1  state is not IDLE.
- err  out  1  input order violation (optional feature; tied 0 when disabled).

Behaviour:
- Reset values: state=IDLE; regA, regB, outbuf, idx and cnt all 0. Outputs: mrg_a=mrg_b=0, out_valid=0, out_data=0, out_last=0, busy=0, err=0. in_ready=0 while rst is high.
- mrg_a and mrg_b are driven directly from regA and regB at all times.
- in_ready = (state==IDLE) & ~rst. It is never high in any other state, so only one transaction is in flight.
- IDLE: on in_valid&in_ready, register regA<=in_a and regB<=in_b, set cnt<=SETTLE-1, go to WAIT.
- WAIT: if cnt==0, set outbuf<=mrg_c and idx<=0, then go to EMIT; otherwise cnt<=cnt-1. WAIT therefore lasts exactly SETTLE cycles.
- EMIT: out_valid=1, out_data=outbuf word[idx], out_last=(idx==2N-1).
  - On out_valid&out_ready: if idx==2N-1, go to IDLE; else idx<=idx+1.
- Latency: a handshake at edge E0 gives the first out_valid in the cycle after edge E0+SETTLE. Minimum transaction length is 1+SETTLE+2N cycles.
- Backpressure: once out_valid is asserted it stays high, and out_data/out_last stay stable, until the word is accepted. Words are never skipped or duplicated.
- out_valid, out_data and out_last are decoded from the registered state, idx and outbuf; they have no combinational path from out_ready.
- idx is $clog2(2N) bits wide and never wraps past 2N-1.
- Duplicate keys are legal. Output order among equal keys is whatever the network produces; the controller does not reorder.
- Reset mid-operation (any state): async return to IDLE, all registers cleared, out_valid drops immediately, the partial transaction is discarded, and nothing is replayed after reset.
- in_valid in a non-IDLE state is ignored; the source must hold it until in_ready is high.

Optional Feature:
- Macro: MERGE_SORT_CHECK_EN.
- Defined:
  - At the input handshake, err<=1 if any word k+1 < word k (unsigned) in in_a or in_b; otherwise err<=0.
  - err holds its value until the next accepted transaction or reset.
  - Data is merged and emitted regardless of err.
- Undefined: err is constant 0 and no checking logic is built.

Test Plan:
- Reset: assert rst during activity → out_valid=0, busy=0, err=0. After release, in_ready=1 and busy=0.
- Basic merge (WIDTH=3, N=4, SETTLE=1): in_a words [1,3,5,7], in_b [0,2,4,6], out_ready=1 → out_data 0,1,…,7 on consecutive cycles. First out_valid appears 2 cycles after the handshake edge, out_last only on the word 7, then busy=0.
- Backpressure: same data with out_ready toggling 1,0,0,1,… → out_data held stable while stalled, all 8 words delivered in order, in_ready=0 throughout.
- Reset mid-EMIT: after 3 words are accepted, pulse rst → out_valid drops at once. A new transaction a=[0,0,1,1], b=[0,1,1,1] then emits 0,0,0,1,1,1,1,1.
- Latency/duplicates with SETTLE=3: a=[2,2,2,2], b=[2,2,2,2] → eight 2s; first out_valid in the cycle after edge E0+3.
- MERGE_SORT_CHECK_EN defined: a=[3,1,4,5] → err=1 and 8 words still emitted. Next transaction with sorted inputs → err=0.
